// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one multi-cycle ALU between two requesters.
// Define ALU_ARB_TIMEOUT_EN to add the WAIT-state timeout and the err0/err1 outputs.
module alu_arbiter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OPW   = 3
`ifdef ALU_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [OPW-1:0]   op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             ack0,
  output logic [WIDTH-1:0] res_lo0,
  output logic [WIDTH-1:0] res_hi0,
  input  logic             req1,
  input  logic [OPW-1:0]   op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack1,
  output logic [WIDTH-1:0] res_lo1,
  output logic [WIDTH-1:0] res_hi1,
  output logic             alu_start,
  output logic [OPW-1:0]   alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result_low,
  input  logic [WIDTH-1:0] alu_result_high,
  input  logic             alu_done,
`ifdef ALU_ARB_TIMEOUT_EN
  output logic             err0,
  output logic             err1,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e           state_q;
  logic             grant_q;
  logic             last_q;
  logic             pick;
  logic             start_q;
  logic             ack0_q;
  logic             ack1_q;
  logic [OPW-1:0]   opcode_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] lo0_q;
  logic [WIDTH-1:0] hi0_q;
  logic [WIDTH-1:0] lo1_q;
  logic [WIDTH-1:0] hi1_q;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic            err0_q;
  logic            err1_q;
  logic [CntW-1:0] cnt_q;
  logic            timeout;

  // Fires in the last allowed WAIT cycle so RESP lands TIMEOUT_CYCLES after WAIT entry.
  assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  assign err0    = err0_q;
  assign err1    = err1_q;
`endif

  // On a tie the requester that did not win last time is chosen.
  assign pick = (req0 && req1) ? ~last_q : req1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      start_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      opcode_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      lo0_q    <= '0;
      hi0_q    <= '0;
      lo1_q    <= '0;
      hi1_q    <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      cnt_q    <= '0;
`endif
    end else begin
      start_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (req0 || req1) begin
            grant_q  <= pick;
            last_q   <= pick;
            opcode_q <= pick ? op1 : op0;
            a_q      <= pick ? a1 : a0;
            b_q      <= pick ? b1 : b0;
            start_q  <= 1'b1;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          state_q <= StWait;
`ifdef ALU_ARB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        StWait: begin
          if (alu_done) begin
            if (grant_q) begin
              lo1_q  <= alu_result_low;
              hi1_q  <= alu_result_high;
              ack1_q <= 1'b1;
            end else begin
              lo0_q  <= alu_result_low;
              hi0_q  <= alu_result_high;
              ack0_q <= 1'b1;
            end
            state_q <= StResp;
          end
`ifdef ALU_ARB_TIMEOUT_EN
          else if (timeout) begin
            if (grant_q) begin
              lo1_q  <= '0;
              hi1_q  <= '0;
              ack1_q <= 1'b1;
              err1_q <= 1'b1;
            end else begin
              lo0_q  <= '0;
              hi0_q  <= '0;
              ack0_q <= 1'b1;
              err0_q <= 1'b1;
            end
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
`endif
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy       = (state_q != StIdle);
  assign alu_start  = start_q;
  assign alu_opcode = opcode_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign res_lo0    = lo0_q;
  assign res_hi0    = hi0_q;
  assign res_lo1    = lo1_q;
  assign res_hi1    = hi1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU stub plus a round-robin reference model.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1;
  logic [2:0]  op0, op1;
  logic [15:0] a0, b0, a1, b1;
  logic        ack0, ack1;
  logic [15:0] res_lo0, res_hi0, res_lo1, res_hi1;
  logic        alu_start;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_a, alu_b;
  logic [15:0] alu_result_low, alu_result_high;
  logic        alu_done;
  logic        busy;
  logic        err0, err1;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state
  bit          model_last;
  logic [15:0] m_lo[2];
  logic [15:0] m_hi[2];

  // ALU stub controls
  bit alu_hang   = 0;
  bit stale_done = 0;
  int alu_cnt    = 0;
  bit nat_done_q = 0;

  alu_arbiter #(
    .WIDTH(16),
    .OPW(3)
`ifdef ALU_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .ack0(ack0), .res_lo0(res_lo0), .res_hi0(res_hi0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .ack1(ack1), .res_lo1(res_lo1), .res_hi1(res_hi1),
    .alu_start(alu_start), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result_low(alu_result_low), .alu_result_high(alu_result_high),
    .alu_done(alu_done),
`ifdef ALU_ARB_TIMEOUT_EN
    .err0(err0), .err1(err1),
`endif
    .busy(busy)
  );

`ifndef ALU_ARB_TIMEOUT_EN
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Golden ALU behaviour: {high, low}
  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [31:0] r;
    case (op)
      3'd0:    r = {16'h0, a} + {16'h0, b};
      3'd1:    r = {(a < b) ? 16'hFFFF : 16'h0000, a - b};
      3'd2:    r = {16'h0, a} * {16'h0, b};
      3'd3:    r = (b == 16'h0) ? {a, 16'hFFFF} : {a % b, a / b};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // ALU stub: acts 2 time units after the edge so it never races the main process.
  initial begin
    logic [31:0] r;
    alu_done        = 1'b0;
    alu_result_low  = '0;
    alu_result_high = '0;
    forever begin
      @(posedge clk);
      #2;
      if (nat_done_q) check_eq("ack_one_cycle_after_done", ack0 | ack1, 1);
      nat_done_q      = 0;
      alu_done        = 1'b0;
      alu_result_low  = 16'($urandom);
      alu_result_high = 16'($urandom);
      if (alu_cnt > 0) begin
        alu_cnt--;
        if (alu_cnt == 0) begin
          r               = alu_fn(alu_opcode, alu_a, alu_b);
          alu_result_low  = r[15:0];
          alu_result_high = r[31:16];
          alu_done        = 1'b1;
          nat_done_q      = 1;
        end
      end
      if (alu_start) begin
        check_eq("start_while_alu_busy", alu_cnt, 0);
        if (!alu_hang) alu_cnt = $urandom_range(1, 5);
      end
      if (stale_done) alu_done = 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    model_last = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_lo[i] = '0;
      m_hi[i] = '0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctl"}, {busy, ack0, ack1, alu_start, alu_opcode, alu_a, alu_b, err0, err1},
             64'h0);
    check_eq({tag, "_res"}, {res_lo0, res_hi0, res_lo1, res_hi1}, 64'h0);
  endtask

  // Raise the requested reqs and collect nops acks. When more ops than requesters are asked
  // for, reqs stay high continuously and grants must alternate.
  task automatic serve(input bit w0, input bit w1, input int nops, input bit scramble);
    logic [2:0]  s_op[2];
    logic [15:0] s_a[2];
    logic [15:0] s_b[2];
    logic [31:0] exp_r;
    int          exp_who;
    int          who;
    int          got;
    int          guard;
    bit          hold;
    s_op[0] = op0; s_a[0] = a0; s_b[0] = b0;
    s_op[1] = op1; s_a[1] = a1; s_b[1] = b1;
    hold    = (nops > (int'(w0) + int'(w1)));
    exp_who = (w0 && w1) ? (model_last ? 0 : 1) : (w1 ? 1 : 0);
    got     = 0;
    guard   = 0;
    req0    = w0;
    req1    = w1;
    while (got < nops && guard < 400) begin
      tick();
      guard++;
      if (guard == 1) check_eq("start_latency", alu_start, 1);
      if (scramble && busy && !alu_start) begin
        a0 = 16'($urandom);
        b0 = 16'($urandom);
      end
      if (ack0 || ack1) begin
        who = ack1 ? 1 : 0;
        check_eq("ack_grant", {ack0, ack1}, (exp_who == 0) ? 2'b10 : 2'b01);
        check_eq("alu_operands_held", {alu_opcode, alu_a, alu_b},
                 {s_op[exp_who], s_a[exp_who], s_b[exp_who]});
        exp_r = alu_fn(s_op[exp_who], s_a[exp_who], s_b[exp_who]);
        m_lo[exp_who] = exp_r[15:0];
        m_hi[exp_who] = exp_r[31:16];
        model_last    = exp_who[0];
        check_eq("res_requester0", {res_hi0, res_lo0}, {m_hi[0], m_lo[0]});
        check_eq("res_requester1", {res_hi1, res_lo1}, {m_hi[1], m_lo[1]});
        check_eq("err_normal", {err0, err1}, 2'b00);
        got++;
        if (!hold) begin
          if (who == 0) req0 = 1'b0;
          else req1 = 1'b0;
        end
        exp_who = 1 - exp_who;
      end
    end
    if (guard >= 400) check_eq("serve_timeout_acks", got, nops);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    check_eq("idle_after_serve", {busy, ack0, ack1}, 3'b000);
  endtask

  initial begin
    int w;
    int nops;
    bit hold;
    int start_cyc;
    int guard;
    reset = 1'b0;
    req0 = 0; req1 = 0;
    op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    model_reset();
    repeat (3) tick();
    check_reset_outputs("reset_state");
    reset = 1'b1;
    tick();

    // Simultaneous requests right after reset: requester 0 wins, then requester 1
    op0 = 3'd2; a0 = 16'd10; b0 = 16'd3;
    op1 = 3'd1; a1 = 16'd10; b1 = 16'd3;
    serve(1, 1, 2, 0);
    check_eq("tie_res_lo0", res_lo0, 16'd30);
    check_eq("tie_res_lo1", res_lo1, 16'd7);

    // Requester 0 alone
    op0 = 3'd0; a0 = 16'd10; b0 = 16'd3;
    serve(1, 0, 1, 0);
    check_eq("add_res_lo0", res_lo0, 16'd13);
    check_eq("add_res_hi0", res_hi0, 16'd0);

    // Continuous requests alternate for four operations
    op0 = 3'd0; a0 = 16'd100; b0 = 16'd23;
    op1 = 3'd3; a1 = 16'd100; b1 = 16'd7;
    serve(1, 1, 4, 0);

    // Operand change during WAIT must not leak into the ALU
    op0 = 3'd2; a0 = 16'h1234; b0 = 16'h0100;
    serve(1, 0, 1, 1);
    check_eq("mul_res_hi0", res_hi0, 16'h0012);
    check_eq("mul_res_lo0", res_lo0, 16'h3400);

    // Reset during WAIT, then a stale done
    alu_hang = 1;
    op0 = 3'd2; a0 = 16'h00FF; b0 = 16'h0003;
    req0 = 1'b1;
    repeat (4) tick();
    check_eq("busy_before_abort", busy, 1);
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset_abort");
    req0 = 1'b0;
    model_reset();
    tick();
    reset    = 1'b1;
    alu_hang = 0;
    tick();
    tick();
    stale_done = 1;
    tick();
    stale_done = 0;
    repeat (4) begin
      tick();
      check_eq("stale_done_ignored", {busy, ack0, ack1}, 3'b000);
    end
    op1 = 3'd0; a1 = 16'd1; b1 = 16'd1;
    serve(0, 1, 1, 0);
    check_eq("post_reset_res_lo1", res_lo1, 16'd2);

`ifdef ALU_ARB_TIMEOUT_EN
    alu_hang = 1;
    op0 = 3'd0; a0 = 16'd5; b0 = 16'd6;
    req0 = 1'b1;
    start_cyc = -1;
    guard = 0;
    while (!(ack0 || ack1) && guard < 100) begin
      tick();
      guard++;
      if (alu_start) start_cyc = cyc;
    end
    check_eq("timeout_ack_seen", {ack0, ack1}, 2'b10);
    check_eq("timeout_cycles_after_wait", cyc - (start_cyc + 1), 8);
    check_eq("timeout_err", {err0, err1}, 2'b10);
    check_eq("timeout_res0", {res_hi0, res_lo0}, 32'h0);
    m_lo[0] = '0;
    m_hi[0] = '0;
    model_last = 1'b0;
    req0 = 1'b0;
    alu_hang = 0;
    tick();
    op0 = 3'd1; a0 = 16'd50; b0 = 16'd8;
    serve(1, 0, 1, 0);
    check_eq("after_timeout_res_lo0", res_lo0, 16'd42);
`else
    start_cyc = 0;
    guard = 0;
`endif

    // Randomized traffic
    for (int i = 0; i < 30; i++) begin
      w    = $urandom_range(1, 3);
      hold = (w == 3) && ($urandom_range(0, 3) == 0);
      nops = hold ? $urandom_range(3, 5) : ((w == 3) ? 2 : 1);
      op0 = 3'($urandom_range(0, 3)); a0 = 16'($urandom); b0 = 16'($urandom);
      op1 = 3'($urandom_range(0, 3)); a1 = 16'($urandom); b1 = 16'($urandom);
      serve(w[0], w[1], nops, (w == 1) && ($urandom_range(0, 1) == 1));
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single multi-cycle ALU (start/done handshake, 16-bit operands, low/high result) between two requesters.
- Requester 0 is the control unit execute stage; requester 1 is an auxiliary client (e.g. debug/DMA).
- Round-robin arbitration; operands and opcode are latched and held stable for the whole operation.
- Results are returned to the granted requester with a one-cycle ack pulse.

Parameters:
- WIDTH, 16, operand/result width.
- OPW, 3, ALU opcode width.
- TIMEOUT_CYCLES, 64, cycles allowed in WAIT before abort (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0  input  1  requester 0 request; held high with operands stable until ack0.
- op0  input  OPW  requester 0 opcode (000 ADD, 001 SUB, 010 MUL, 011 DIV).
- a0, b0  input  WIDTH  requester 0 operands.
- ack0  output  1  one-cycle pulse; res_lo0/res_hi0 valid this cycle and held after.
- res_lo0, res_hi0  output  WIDTH  requester 0 result low/high.
- req1, op1, a1, b1, ack1, res_lo1, res_hi1: same as the requester 0 ports, for requester 1.
- alu_start  output  1  one-cycle start pulse to the ALU.
- alu_opcode  output  OPW  latched opcode to the ALU.
- alu_a, alu_b  output  WIDTH  latched operands to the ALU.
- alu_result_low, alu_result_high  input  WIDTH  ALU results.
- alu_done  input  1  ALU completion.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - Reset asserted mid-operation aborts immediately. No ack is issued, and a later alu_done is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Requests are sampled only here.
  - Only one request high: grant it.
  - Both high: grant the requester other than last_grant.
  - On grant, latch op/a/b into alu_opcode/alu_a/alu_b, record grant and last_grant, go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - alu_start=1 for exactly this cycle.
  - Go to WAIT.
  - alu_done is ignored during ISSUE.
- WAIT:
  - alu_done=1: capture alu_result_low/high into the granted requester's res registers, go to RESP.
  - Otherwise stay in WAIT.
- RESP:
  - ack of the granted requester = 1 for this cycle only.
  - Go to IDLE.
- Latency:
  - Request sampled in IDLE at cycle N gives alu_start at N+1.
  - alu_done at cycle D gives ack at D+1.
  - New grant possible at D+2 (the IDLE cycle after RESP).
- Requester contract:
  - The requester deasserts req in the cycle after ack.
  - If req is still high in the following IDLE, it is a new request and competes under round-robin. A continuous req0 and req1 therefore alternate.
- A req dropped after grant does not cancel the operation; ack still pulses.
- res_loX/res_hiX change only on that requester's capture and hold otherwise.
- alu_opcode/a/b are stable from ISSUE until the next grant.
- alu_done outside WAIT has no effect.
- Results are passed through unmodified. No width extension or arithmetic is performed in the arbiter.

Optional Feature:
- Macro ALU_ARB_TIMEOUT_EN.
- When defined:
  - Adds outputs err0/err1 (1 bit, reset 0).
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without alu_done, go to RESP with the granted requester's ack=1 and err=1 for that cycle.
  - That requester's res_lo/res_hi are written to 0.
  - alu_done arriving in the same cycle as the limit wins: normal completion, err=0.
- When not defined: no err ports and no counter; WAIT waits indefinitely.

Test Plan:
- Requester 0 alone, op0=000, a0=10, b0=3:
  - alu_start exactly 1 cycle after the grant cycle.
  - ack0 pulses once, res_lo0=13, res_hi0=0.
  - ack1 stays 0 and res_lo1 is unchanged.
- req0 (MUL 10*3) and req1 (SUB 10-3) raised in the same cycle after reset:
  - Requester 0 is served first: ack0 with res_lo0=30.
  - Then ack1 with res_lo1=7.
- Both requests held high continuously for 4 operations:
  - Grants alternate 0,1,0,1.
  - alu_start never overlaps busy WAIT; each op has exactly one alu_start.
- req0 MUL 0x1234*0x0100 while a0 is changed during WAIT:
  - alu_a stays 0x1234.
  - res_hi0=0x0012, res_lo0=0x3400.
- reset pulled low during WAIT:
  - All outputs 0 and FSM in IDLE.
  - The stale alu_done pulse 3 cycles later produces no ack.
  - The next req1 ADD 1+1 returns res_lo1=2.
- With ALU_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, ALU stubbed never asserting done:
  - ack0 and err0 pulse 8 cycles after entering WAIT, res_lo0=0.
  - The next request is served normally.
